// File: rtl/auto_player.sv
// Auto-play sequencer: walks one song's note table in an external
// synchronous ROM and drives the tone generator one note at a time,
// each note held for its programmed beat count, with a fixed silent gap
// between notes and a one-cycle done pulse at the end of the song.
module auto_player #(
    parameter int BEAT_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 1_000_000,
    parameter int IDX_W       = 2,
    parameter int PTR_W       = 8,
    parameter int NOTE_W      = 6,
    parameter int BEAT_W      = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable,
    input  logic [7:0]                index,
    input  logic                      play,
    input  logic                      stop,
    output logic [IDX_W+PTR_W-1:0]    rom_addr,
    input  logic [NOTE_W+BEAT_W-1:0]  rom_data,
    output logic [NOTE_W-1:0]         note,
    output logic                      note_valid,
    output logic                      playing,
    output logic                      done
);

    // Longest note is BEAT_CYCLES times the largest beat field value.
    localparam int BEAT_MAX = BEAT_CYCLES * (2**BEAT_W - 1);
    localparam int CNT_W    = $clog2(BEAT_MAX + 1);
    localparam int GAP_W    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

    localparam logic [CNT_W-1:0] BEAT_CYC_C = CNT_W'(BEAT_CYCLES);
    localparam logic [GAP_W-1:0] GAP_LOAD_C = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_NOTE,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state_reg,      state_next;
    logic [IDX_W-1:0]   song_reg,       song_next;
    logic [PTR_W-1:0]   ptr_reg,        ptr_next;
    logic [CNT_W-1:0]   beat_cnt_reg,   beat_cnt_next;
    logic [GAP_W-1:0]   gap_cnt_reg,    gap_cnt_next;
    logic [NOTE_W-1:0]  note_reg,       note_next;
    logic               note_valid_reg, note_valid_next;
    logic [IDX_W+PTR_W-1:0] rom_addr_reg, rom_addr_next;
    logic               play_d_reg;

    logic               play_edge;
    logic [NOTE_W-1:0]  rom_note;
    logic [BEAT_W-1:0]  rom_beats;
    logic [CNT_W-1:0]   beat_load;

    // Only the low IDX_W bits of the selector index pick a song.
    logic unused_index;
    assign unused_index = ^index[7:IDX_W];

    assign play_edge = play & ~play_d_reg;
    assign rom_note  = rom_data[NOTE_W+BEAT_W-1:BEAT_W];
    assign rom_beats = rom_data[BEAT_W-1:0];
    // Counter runs down to zero, so load one less than the note length.
    assign beat_load = CNT_W'(rom_beats) * BEAT_CYC_C - CNT_W'(1);

    assign rom_addr   = rom_addr_reg;
    assign note       = note_reg;
    assign note_valid = note_valid_reg;
    assign playing    = (state_reg != S_IDLE);
    assign done       = (state_reg == S_DONE);

    // State and datapath registers; play history is tracked every cycle so
    // an edge seen while disabled is consumed rather than queued.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= S_IDLE;
            song_reg       <= '0;
            ptr_reg        <= '0;
            beat_cnt_reg   <= '0;
            gap_cnt_reg    <= '0;
            note_reg       <= '0;
            note_valid_reg <= 1'b0;
            rom_addr_reg   <= '0;
            play_d_reg     <= 1'b0;
        end else begin
            state_reg      <= state_next;
            song_reg       <= song_next;
            ptr_reg        <= ptr_next;
            beat_cnt_reg   <= beat_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
            note_reg       <= note_next;
            note_valid_reg <= note_valid_next;
            rom_addr_reg   <= rom_addr_next;
            play_d_reg     <= play;
        end
    end

    // Next-state logic: everything holds by default, which is also how
    // a pause (enable low outside IDLE) freezes the sequencer.
    always_comb begin
        state_next      = state_reg;
        song_next       = song_reg;
        ptr_next        = ptr_reg;
        beat_cnt_next   = beat_cnt_reg;
        gap_cnt_next    = gap_cnt_reg;
        note_next       = note_reg;
        note_valid_next = note_valid_reg;
        rom_addr_next   = rom_addr_reg;

        if (state_reg == S_IDLE) begin
            // stop wins over a simultaneous play edge
            if (play_edge && enable && !stop) begin
                song_next     = index[IDX_W-1:0];
                ptr_next      = '0;
                rom_addr_next = {index[IDX_W-1:0], {PTR_W{1'b0}}};
                state_next    = S_FETCH;
            end
        end else if (stop) begin
            // Abort works even while paused and never pulses done.
            state_next      = S_IDLE;
            ptr_next        = '0;
            beat_cnt_next   = '0;
            gap_cnt_next    = '0;
            note_next       = '0;
            note_valid_next = 1'b0;
        end else if (enable) begin
            case (state_reg)
                S_FETCH: begin
                    state_next = S_LOAD;
                end
                S_LOAD: begin
                    if (rom_beats == '0) begin
                        state_next = S_DONE;
                    end else begin
                        note_next       = rom_note;
                        note_valid_next = 1'b1;
                        beat_cnt_next   = beat_load;
                        state_next      = S_NOTE;
                    end
                end
                S_NOTE: begin
                    if (beat_cnt_reg == '0) begin
                        note_next       = '0;
                        note_valid_next = 1'b0;
                        gap_cnt_next    = GAP_LOAD_C;
                        state_next      = S_GAP;
                    end else begin
                        beat_cnt_next = beat_cnt_reg - CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (gap_cnt_reg != '0) begin
                        gap_cnt_next = gap_cnt_reg - GAP_W'(1);
                    end else if (ptr_reg == {PTR_W{1'b1}}) begin
                        // Table full: end here instead of wrapping to entry 0.
                        state_next = S_DONE;
                    end else begin
                        ptr_next      = ptr_reg + PTR_W'(1);
                        rom_addr_next = {song_reg, ptr_reg + PTR_W'(1)};
                        state_next    = S_FETCH;
                    end
                end
                S_DONE: begin
                    state_next = S_IDLE;
                end
                default: begin
                    state_next = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_auto_player.sv
// Bench for auto_player: behavioural ROM, negedge monitor feeding a note
// scoreboard, and directed scenarios for timing, pause, stop, ignored
// inputs and the full 256-entry table.
module tb_auto_player;

    localparam int BEAT = 4;
    localparam int GAP  = 2;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [7:0] index;
    logic       play;
    logic       stop;
    logic [9:0] rom_addr;
    logic [9:0] rom_data;
    logic [5:0] note;
    logic       note_valid;
    logic       playing;
    logic       done;

    auto_player #(
        .BEAT_CYCLES (BEAT),
        .GAP_CYCLES  (GAP),
        .IDX_W       (2),
        .PTR_W       (8),
        .NOTE_W      (6),
        .BEAT_W      (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .index      (index),
        .play       (play),
        .stop       (stop),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .note       (note),
        .note_valid (note_valid),
        .playing    (playing),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous note ROM, 4 songs x 256 entries of {note, beats}.
    logic [9:0] rom_mem [0:1023];
    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [5:0] n;
        int         len;
    } seg_t;
    seg_t seg_q[$];

    int exp_done   = 0;
    int done_cnt   = 0;
    int pulse_err  = 0;
    int silent_err = 0;
    int addr_err   = 0;

    task automatic push_seg(input logic [5:0] n, input int beats);
        seg_t s;
        s.n   = n;
        s.len = beats * BEAT;
        seg_q.push_back(s);
    endtask

    // Monitor: measures each sounding segment and compares it with the
    // scoreboard; also tracks done pulses, silence and ROM address steps.
    logic       nv_prev   = 1'b0;
    logic       done_prev = 1'b0;
    logic       play_prev = 1'b0;
    logic [9:0] addr_prev = '0;
    logic [5:0] seg_note  = '0;
    int         seg_len   = 0;
    logic       seg_bad   = 1'b0;

    always @(negedge clk) begin
        if (rst_n) begin
            if (note_valid && !nv_prev) begin
                seg_note = note;
                seg_len  = 1;
                seg_bad  = 1'b0;
            end else if (note_valid) begin
                seg_len++;
                if (note != seg_note) seg_bad = 1'b1;
            end
            if (!note_valid && nv_prev) begin
                if (seg_q.size() == 0) begin
                    check("seg_unexpected", seg_note, 0);
                end else begin
                    seg_t e;
                    e = seg_q.pop_front();
                    check("seg_note", seg_note, e.n);
                    check("seg_len", seg_len, e.len);
                    check("seg_steady", seg_bad, 0);
                end
            end
            if (!note_valid && note != 6'd0) silent_err++;
            if (done) done_cnt++;
            if (done && done_prev) pulse_err++;
            if (play_prev && rom_addr != addr_prev) begin
                if (rom_addr[9:8] != addr_prev[9:8] ||
                    {1'b0, rom_addr[7:0]} != {1'b0, addr_prev[7:0]} + 9'd1)
                    addr_err++;
            end
        end
        nv_prev   = note_valid;
        done_prev = done;
        play_prev = playing;
        addr_prev = rom_addr;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_song(input logic [7:0] idx);
        index = idx;
        play  = 1'b1;
        tick();
        play  = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!playing) break;
        end
        check(tag, playing, 0);
    endtask

    task automatic wait_note(input string tag, input logic [5:0] n, input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (note_valid && note == n) break;
        end
        check(tag, note, n);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) rom_mem[i] = '0;
        // song 1: one note then end marker
        rom_mem[10'h100] = {6'd5, 4'd2};
        rom_mem[10'h101] = {6'd0, 4'd0};
        // song 2: four notes then end marker
        rom_mem[10'h200] = {6'd7, 4'd3};
        rom_mem[10'h201] = {6'd9, 4'd1};
        rom_mem[10'h202] = {6'd11, 4'd2};
        rom_mem[10'h203] = {6'd13, 4'd1};
        rom_mem[10'h204] = {6'd0, 4'd0};
        // song 3: full table, no end marker
        for (int i = 0; i < 256; i++)
            rom_mem[10'h300 + i] = {6'((i % 63) + 1), 4'((i % 3) + 1)};

        rst_n  = 1'b0;
        enable = 1'b0;
        play   = 1'b1;
        stop   = 1'b0;
        index  = 8'd1;

        // Reset held with play high: everything stays zero.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("rst_addr", rom_addr, 0);
            check("rst_note", note, 0);
            check("rst_nv", note_valid, 0);
            check("rst_playing", playing, 0);
            check("rst_done", done, 0);
        end
        tick();
        // Release with play still high but disabled: the edge is discarded.
        rst_n = 1'b1;
        tick();
        tick();
        enable = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check("disabled_edge_dropped", playing, 0);
        end
        tick();
        play = 1'b0;
        tick();

        // Single note, cycle-exact.
        push_seg(6'd5, 2);
        exp_done++;
        index = 8'd1;
        play  = 1'b1;
        for (int c = 0; c <= 17; c++) begin
            logic [9:0] ea;
            logic [5:0] en;
            @(negedge clk);
            ea = (c == 0) ? 10'h000 : (c < 13) ? 10'h100 : 10'h101;
            en = (c >= 3 && c <= 10) ? 6'd5 : 6'd0;
            check($sformatf("c%0d_addr", c), rom_addr, ea);
            check($sformatf("c%0d_note", c), note, en);
            check($sformatf("c%0d_nv", c), note_valid, (c >= 3 && c <= 10));
            check($sformatf("c%0d_done", c), done, (c == 15));
            check($sformatf("c%0d_playing", c), playing, (c >= 1 && c <= 15));
            if (c == 2) play = 1'b0;
        end
        tick();

        // Pause for 5 cycles inside the first note of song 2.
        push_seg(6'd7, 3 + 5 * 0);
        seg_q[seg_q.size()-1].len = 3 * BEAT + 5;
        push_seg(6'd9, 1);
        push_seg(6'd11, 2);
        push_seg(6'd13, 1);
        exp_done++;
        start_song(8'd2);
        wait_note("pause_note_start", 6'd7, 20);
        tick();
        tick();
        tick();
        enable = 1'b0;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check("pause_note_held", note, 7);
            check("pause_nv_held", note_valid, 1);
            tick();
        end
        enable = 1'b1;
        wait_idle("pause_song_end", 300);
        tick();

        // Stop during the gap after entry 3.
        push_seg(6'd7, 3);
        push_seg(6'd9, 1);
        push_seg(6'd11, 2);
        push_seg(6'd13, 1);
        start_song(8'd2);
        wait_note("stop_reach_e3", 6'd13, 200);
        for (int i = 0; i < 20; i++) begin
            if (!note_valid) break;
            @(negedge clk);
        end
        check("stop_in_gap", note_valid, 0);
        check("stop_gap_playing", playing, 1);
        stop = 1'b1;
        @(negedge clk);
        check("stop_idle", playing, 0);
        check("stop_note", note, 0);
        check("stop_nv", note_valid, 0);
        stop = 1'b0;
        for (int i = 0; i < 5; i++) @(negedge clk);
        check("stop_no_done", done_cnt, exp_done);
        tick();
        // Restart begins at entry 0; then stop while paused.
        start_song(8'd2);
        @(negedge clk);
        check("restart_addr", rom_addr, 10'h200);
        tick();
        enable = 1'b0;
        tick();
        tick();
        stop = 1'b1;
        tick();
        @(negedge clk);
        check("stop_paused_idle", playing, 0);
        stop   = 1'b0;
        enable = 1'b1;
        tick();

        // Index change and play re-pulse mid-song are ignored.
        push_seg(6'd5, 2);
        exp_done++;
        start_song(8'd1);
        wait_note("ign_note", 6'd5, 20);
        index = 8'd2;
        play  = 1'b1;
        tick();
        play  = 1'b0;
        wait_idle("ign_song_end", 100);
        check("ign_addr_song", rom_addr[9:8], 1);
        for (int i = 0; i < 6; i++) @(negedge clk);
        check("ign_no_restart", playing, 0);
        tick();
        // play and stop together in IDLE: no start.
        stop = 1'b1;
        play = 1'b1;
        tick();
        tick();
        play = 1'b0;
        stop = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("play_stop_idle", playing, 0);
        end
        tick();

        // Full 256-entry song: ends after entry 255 without wrapping.
        for (int i = 0; i < 256; i++)
            push_seg(6'((i % 63) + 1), (i % 3) + 1);
        exp_done++;
        start_song(8'd3);
        wait_idle("wrap_song_end", 6000);
        check("wrap_last_addr", rom_addr, 10'h3FF);
        tick();
        tick();

        check("done_count", done_cnt, exp_done);
        check("done_one_cycle", pulse_err, 0);
        check("silent_note_zero", silent_err, 0);
        check("addr_steps", addr_err, 0);
        check("seg_queue_empty", seg_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
